// File: rtl/srf_access_arbiter_if.sv
// Bundle of SRF access arbiter signals: requester handshakes, SRF port, returned read data, perf counters.
// slave = arbiter side, master = functional units / read client / SRF side.
interface srf_access_arbiter_if #(
    parameter int NUM_WR              = 4,
    parameter int NUM_STREAM_ID       = 5,
    parameter int MIN_VEC_LENGTH      = 16,
    parameter int NUM_TILES_PER_SLICE = 20
);
    logic [NUM_WR-1:0]                                            wr_valid;
    logic [NUM_WR-1:0][NUM_STREAM_ID-1:0]                         wr_stream_id;
    logic [NUM_WR-1:0][NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0] wr_data;
    logic [NUM_WR-1:0]                                            wr_ready;

    logic                                                         rd_valid;
    logic [NUM_STREAM_ID-1:0]                                     rd_stream_id;
    logic                                                         rd_ready;

    logic                                                         rd_data_valid;
    logic [NUM_STREAM_ID-1:0]                                     rd_data_stream_id;
    logic [NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0]           rd_data;

    logic                                                         srf_write_enable;
    logic [NUM_STREAM_ID-1:0]                                     srf_stream_id;
    logic [NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0]           srf_write_data;
    logic [NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0]           srf_data;

    logic [31:0]                                                  perf_wr_grants;
    logic [31:0]                                                  perf_rd_grants;
    logic [31:0]                                                  perf_stall_cycles;

    modport slave (
        input  wr_valid, wr_stream_id, wr_data, rd_valid, rd_stream_id, srf_data,
        output wr_ready, rd_ready, rd_data_valid, rd_data_stream_id, rd_data,
               srf_write_enable, srf_stream_id, srf_write_data,
               perf_wr_grants, perf_rd_grants, perf_stall_cycles
    );

    modport master (
        output wr_valid, wr_stream_id, wr_data, rd_valid, rd_stream_id, srf_data,
        input  wr_ready, rd_ready, rd_data_valid, rd_data_stream_id, rd_data,
               srf_write_enable, srf_stream_id, srf_write_data,
               perf_wr_grants, perf_rd_grants, perf_stall_cycles
    );
endinterface

// File: rtl/srf_access_arbiter.sv
// Single-port SRF arbiter: round-robin writes vs. one read with anti-starvation, registered SRF drive.
// Optional grant/stall counters enabled by defining SRF_ARB_PERF_CNT_EN.
module srf_access_arbiter #(
    parameter int NUM_WR              = 4,
    parameter int NUM_STREAM_ID       = 5,
    parameter int MIN_VEC_LENGTH      = 16,
    parameter int NUM_TILES_PER_SLICE = 20,
    parameter int STARVE_LIMIT        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    srf_access_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef logic [NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0] vec_t;
    typedef logic [NUM_STREAM_ID-1:0]                           sid_t;

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             srf_we_q, srf_we_d;
    sid_t             srf_sid_q, srf_sid_d;
    vec_t             srf_wdata_q, srf_wdata_d;
    logic             rd_pend_q, rd_pend_d;
    sid_t             rd_pend_sid_q, rd_pend_sid_d;
    logic             rd_dv_q, rd_dv_d;
    sid_t             rd_dv_sid_q, rd_dv_sid_d;

    logic              any_wr;
    logic              wr_win;
    logic              rd_gnt;
    logic              found;
    logic [PTR_W-1:0]  wr_idx;
    logic [NUM_WR-1:0] wr_gnt;
    int                idx;

    // Read wins unless the writers have waited STARVE_LIMIT consecutive read grants.
    always_comb begin
        any_wr = |bus.wr_valid;
        wr_win = !rst && any_wr &&
                 (!bus.rd_valid || starve_cnt_q == CNT_W'(STARVE_LIMIT));
        rd_gnt = !rst && bus.rd_valid && !wr_win;

        found  = 1'b0;
        wr_idx = '0;
        idx    = 0;
        for (int i = 0; i < NUM_WR; i++) begin
            idx = (int'(rr_ptr_q) + i) % NUM_WR;
            if (!found && bus.wr_valid[idx]) begin
                found  = 1'b1;
                wr_idx = PTR_W'(idx);
            end
        end

        wr_gnt = '0;
        if (wr_win) wr_gnt[wr_idx] = 1'b1;
    end

    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        starve_cnt_d  = starve_cnt_q;
        srf_we_d      = wr_win;
        srf_sid_d     = srf_sid_q;
        srf_wdata_d   = srf_wdata_q;
        rd_pend_d     = rd_gnt;
        rd_pend_sid_d = rd_pend_sid_q;
        rd_dv_d       = rd_pend_q;
        rd_dv_sid_d   = rd_dv_sid_q;

        if (wr_win)
            rr_ptr_d = (wr_idx == PTR_W'(NUM_WR - 1)) ? '0 : wr_idx + 1'b1;

        if (!any_wr || wr_win)
            starve_cnt_d = '0;
        else if (rd_gnt && starve_cnt_q != CNT_W'(STARVE_LIMIT))
            starve_cnt_d = starve_cnt_q + 1'b1;

        if (wr_win) begin
            srf_sid_d   = bus.wr_stream_id[wr_idx];
            srf_wdata_d = bus.wr_data[wr_idx];
        end else if (rd_gnt) begin
            srf_sid_d   = bus.rd_stream_id;
        end

        // Id rides alongside the SRF's one-cycle read latency.
        if (rd_gnt)    rd_pend_sid_d = bus.rd_stream_id;
        if (rd_pend_q) rd_dv_sid_d   = rd_pend_sid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q      <= '0;
            starve_cnt_q  <= '0;
            srf_we_q      <= 1'b0;
            srf_sid_q     <= '0;
            srf_wdata_q   <= '0;
            rd_pend_q     <= 1'b0;
            rd_pend_sid_q <= '0;
            rd_dv_q       <= 1'b0;
            rd_dv_sid_q   <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            starve_cnt_q  <= starve_cnt_d;
            srf_we_q      <= srf_we_d;
            srf_sid_q     <= srf_sid_d;
            srf_wdata_q   <= srf_wdata_d;
            rd_pend_q     <= rd_pend_d;
            rd_pend_sid_q <= rd_pend_sid_d;
            rd_dv_q       <= rd_dv_d;
            rd_dv_sid_q   <= rd_dv_sid_d;
        end
    end

    assign bus.wr_ready          = wr_gnt;
    assign bus.rd_ready          = rd_gnt;
    assign bus.srf_write_enable  = srf_we_q;
    assign bus.srf_stream_id     = srf_sid_q;
    assign bus.srf_write_data    = srf_wdata_q;
    assign bus.rd_data_valid     = rd_dv_q;
    assign bus.rd_data_stream_id = rd_dv_sid_q;
    assign bus.rd_data           = bus.srf_data;

`ifdef SRF_ARB_PERF_CNT_EN
    logic [31:0] perf_wr_q, perf_wr_d;
    logic [31:0] perf_rd_q, perf_rd_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic        stall;

    always_comb begin
        stall        = (|(bus.wr_valid & ~wr_gnt)) || (bus.rd_valid && !rd_gnt);
        perf_wr_d    = perf_wr_q    + {31'd0, wr_win};
        perf_rd_d    = perf_rd_q    + {31'd0, rd_gnt};
        perf_stall_d = perf_stall_q + {31'd0, stall};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_wr_q    <= '0;
            perf_rd_q    <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_wr_q    <= perf_wr_d;
            perf_rd_q    <= perf_rd_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign bus.perf_wr_grants    = perf_wr_q;
    assign bus.perf_rd_grants    = perf_rd_q;
    assign bus.perf_stall_cycles = perf_stall_q;
`else
    assign bus.perf_wr_grants    = '0;
    assign bus.perf_rd_grants    = '0;
    assign bus.perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_srf_access_arbiter.sv
// Directed bench for srf_access_arbiter with a behavioural one-cycle-latency SRF model.
module tb_srf_access_arbiter;
    localparam int NW = 4;
    localparam int NT = 20;
`ifdef SRF_ARB_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef logic [NT-1:0][15:0] vec_t;

    logic clk;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    srf_access_arbiter_if bus ();

    srf_access_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRF model: write commits at the edge, read data registered one cycle later.
    vec_t mem [32];
    always @(posedge clk) begin
        if (bus.srf_write_enable) mem[bus.srf_stream_id] <= bus.srf_write_data;
        bus.srf_data <= mem[bus.srf_stream_id];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_valid = '0;
        bus.rd_valid = 1'b0;
    endtask

    function automatic vec_t fill(input logic [15:0] v);
        vec_t f;
        for (int t = 0; t < NT; t++) f[t] = v;
        return f;
    endfunction

    int ids [4] = '{3, 7, 11, 15};
    logic [3:0] c_rd [8] = '{1, 1, 1, 1, 0, 1, 1, 1};
    logic [3:0] c_wr [8] = '{0, 0, 0, 0, 4, 0, 0, 0};
    logic [3:0] c_dv [8] = '{0, 0, 1, 1, 1, 1, 0, 1};

    initial begin
        rst = 1'b1;
        idle();
        bus.rd_stream_id = 5'd9;
        for (int k = 0; k < NW; k++) begin
            bus.wr_stream_id[k] = 5'(ids[k]);
            bus.wr_data[k]      = fill(16'h1000 + 16'(k));
        end

        // Reset: no grants even with every request raised
        bus.wr_valid = 4'b1111;
        bus.rd_valid = 1'b1;
        #1;
        chk("rst_wr_ready", 64'(bus.wr_ready), 64'h0);
        chk("rst_rd_ready", 64'(bus.rd_ready), 64'h0);
        tick();
        tick();
        chk("rst_we",    64'(bus.srf_write_enable), 64'h0);
        chk("rst_sid",   64'(bus.srf_stream_id), 64'h0);
        chk("rst_wdata", 64'(|bus.srf_write_data), 64'h0);
        chk("rst_dv",    64'(bus.rd_data_valid), 64'h0);
        chk("rst_did",   64'(bus.rd_data_stream_id), 64'h0);
        chk("rst_pwr",   64'(bus.perf_wr_grants), 64'h0);
        chk("rst_prd",   64'(bus.perf_rd_grants), 64'h0);
        chk("rst_pst",   64'(bus.perf_stall_cycles), 64'h0);
        idle();
        rst = 1'b0;

        // All four writers: round-robin 0,1,2,3,0,1
        bus.wr_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_all_gnt", 64'(bus.wr_ready), 64'(4'b0001 << (i % 4)));
            chk("rr_all_rd",  64'(bus.rd_ready), 64'h0);
            tick();
            chk("rr_all_we",  64'(bus.srf_write_enable), 64'h1);
            chk("rr_all_sid", 64'(bus.srf_stream_id), 64'(ids[i % 4]));
            chk("rr_all_dat", 64'(bus.srf_write_data[NT-1]), 64'(16'h1000 + 16'(i % 4)));
        end
        idle();
        tick();
        chk("hold_we",  64'(bus.srf_write_enable), 64'h0);
        chk("hold_sid", 64'(bus.srf_stream_id), 64'd7);

        // Write stream 5 then read it back the very next cycle (rr_ptr=2, search wraps to 0)
        bus.wr_stream_id[0] = 5'd5;
        bus.wr_data[0]      = fill(16'hA5A5);
        bus.wr_valid        = 4'b0001;
        #1;
        chk("wb_wr_gnt", 64'(bus.wr_ready), 64'h1);
        tick();
        idle();
        bus.rd_valid     = 1'b1;
        bus.rd_stream_id = 5'd5;
        #1;
        chk("wb_rd_gnt", 64'(bus.rd_ready), 64'h1);
        chk("wb_wr_none", 64'(bus.wr_ready), 64'h0);
        tick();
        chk("wb_srf_we",  64'(bus.srf_write_enable), 64'h0);
        chk("wb_srf_sid", 64'(bus.srf_stream_id), 64'd5);
        chk("wb_dv_early", 64'(bus.rd_data_valid), 64'h0);
        idle();
        tick();
        chk("wb_dv",    64'(bus.rd_data_valid), 64'h1);
        chk("wb_did",   64'(bus.rd_data_stream_id), 64'd5);
        chk("wb_tile0", 64'(bus.rd_data[0]), 64'hA5A5);
        chk("wb_tile19", 64'(bus.rd_data[NT-1]), 64'hA5A5);
        tick();
        chk("wb_dv_once", 64'(bus.rd_data_valid), 64'h0);

        // Starvation: four reads, write 2 on the fifth cycle, reads resume
        bus.wr_valid     = 4'b0100;
        bus.rd_valid     = 1'b1;
        bus.rd_stream_id = 5'd9;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("stv_rd", 64'(bus.rd_ready), 64'(c_rd[c]));
            chk("stv_wr", 64'(bus.wr_ready), 64'(c_wr[c]));
            chk("stv_dv", 64'(bus.rd_data_valid), 64'(c_dv[c]));
            tick();
        end
        idle();
        tick();
        tick();
        tick();

        // Reset the cycle after a read grant drops the in-flight read
        bus.rd_valid = 1'b1;
        #1;
        chk("rr_rd_gnt", 64'(bus.rd_ready), 64'h1);
        tick();
        rst          = 1'b1;
        bus.rd_valid = 1'b0;
        bus.wr_valid = 4'b1111;
        #1;
        chk("rr_rst_wr", 64'(bus.wr_ready), 64'h0);
        tick();
        chk("rr_dv",  64'(bus.rd_data_valid), 64'h0);
        chk("rr_did", 64'(bus.rd_data_stream_id), 64'h0);
        chk("rr_we",  64'(bus.srf_write_enable), 64'h0);
        chk("rr_sid", 64'(bus.srf_stream_id), 64'h0);
        chk("rr_wdat", 64'(|bus.srf_write_data), 64'h0);
        rst = 1'b0;

        // Sparse writers 1 and 3 from rr_ptr=0: 1,3,1,3
        bus.wr_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("sparse_gnt", 64'(bus.wr_ready), (k % 2 == 0) ? 64'h2 : 64'h8);
            tick();
        end
        idle();
        tick();

        // Counters: 10 writes, 6 reads, 3 contested cycles
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.wr_valid = 4'b0001;
        for (int k = 0; k < 7; k++) tick();
        bus.rd_valid = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        bus.rd_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        bus.wr_valid = '0;
        bus.rd_valid = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        idle();
        tick();
        chk("perf_wr",    64'(bus.perf_wr_grants),    PERF ? 64'd10 : 64'd0);
        chk("perf_rd",    64'(bus.perf_rd_grants),    PERF ? 64'd6  : 64'd0);
        chk("perf_stall", 64'(bus.perf_stall_cycles), PERF ? 64'd3  : 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
